collision_ctrl: RTL

Per-pixel collision detector and game-state controller for the goose-run display pipeline. It sits downstream of the bean and goose drawing stages and consumes their per-pixel `bean` and `goose` flags. It decides once per frame whether the goose has hit a bean, and drives `check_hit` back to the bean stage. It also owns the IDLE/RUN/HIT/OVER game state, the score counter and the restart pulse.

---
 rtl/goose_pkg.sv | 21 ++
 rtl/btn_arm.sv | 20 ++
 rtl/collision_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/goose_pkg.sv
// Shared goose-run definitions: game state encoding, screen geometry defaults
// and score sizing used by the bean, collision and score-display stages.
package goose_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } game_state_t;

  localparam int unsigned H_LAST_DEF    = 639;
  localparam int unsigned V_LAST_DEF    = 479;
  localparam int unsigned SCORE_W       = 14;
  localparam int unsigned SCORE_MAX_DEF = 9999;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/btn_arm.sv
// Press qualification: a press only starts the game if the buttons were seen
// fully released on the previous cycle, so a held button never retriggers.
module btn_arm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] button,
  output logic       start_req
);

  logic arm;

  // Any press consumes the arm; only an all-released sample re-arms.
  always_ff @(posedge clk) begin
    if (!reset) arm <= 1'b0;
    else        arm <= (button == 2'b00);
  end

  assign start_req = (|button) & arm;

endmodule

// File: rtl/collision_ctrl.sv
// Per-frame goose/bean collision detector and IDLE/RUN/HIT/OVER game
// controller, including score, freeze timer and bean-stage restart pulse.
module collision_ctrl
  import goose_pkg::*;
#(
  parameter int unsigned H_LAST        = H_LAST_DEF,
  parameter int unsigned V_LAST        = V_LAST_DEF,
  parameter int unsigned HIT_THRESH    = 4,
  parameter int unsigned FREEZE_FRAMES = 30,
  parameter int unsigned SCORE_DIV     = 6,
  parameter int unsigned SCORE_MAX     = SCORE_MAX_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               goose,
  input  logic               bean,
  input  logic [1:0]         button,
  output logic               check_hit,
  output logic               game_over,
  output logic               running,
  output logic               restart,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         state
);

  localparam int unsigned DIV_W = $clog2(SCORE_DIV);
  localparam int unsigned FRZ_W = $clog2(FREEZE_FRAMES);

  localparam logic [9:0]         X_LAST   = 10'(H_LAST);
  localparam logic [9:0]         Y_LAST   = 10'(V_LAST);
  localparam logic [3:0]         THRESH   = 4'(HIT_THRESH);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SCORE_DIV - 1);
  localparam logic [FRZ_W-1:0]   FRZ_LAST = FRZ_W'(FREEZE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SC_MAX   = SCORE_W'(SCORE_MAX);

  game_state_t        state_q, state_next;
  logic               start_req;
  logic [3:0]         ovl, ovl_next;
  logic [DIV_W-1:0]   div;
  logic [FRZ_W-1:0]   frz;
  logic               fe, hit_px, hit_now;
  logic               check_hit_d, game_over_d, running_d, restart_d;

  btn_arm u_btn_arm (
    .clk       (clk),
    .reset     (reset),
    .button    (button),
    .start_req (start_req)
  );

  assign fe       = (x == X_LAST) && (y == Y_LAST);
  assign hit_px   = (state_q == RUN) && goose && bean && (x <= X_LAST) && (y <= Y_LAST);
  // The frame-end pixel itself is included before the threshold compare.
  assign ovl_next = hit_px ? sat_inc4(ovl) : ovl;
  assign hit_now  = (ovl_next >= THRESH);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:    if (start_req)               state_next = RUN;
      RUN:     if (fe && hit_now)           state_next = HIT;
      HIT:     if (fe && (frz == FRZ_LAST)) state_next = OVER;
      OVER:    if (start_req)               state_next = RUN;
      default:                              state_next = IDLE;
    endcase
  end

  always_comb begin
    check_hit_d = (state_next == HIT) || (state_next == OVER);
    game_over_d = (state_next == OVER);
    running_d   = (state_next == RUN);
    restart_d   = ((state_q == IDLE) || (state_q == OVER)) && start_req;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      check_hit <= 1'b0;
      game_over <= 1'b0;
      running   <= 1'b0;
      restart   <= 1'b0;
    end else begin
      check_hit <= check_hit_d;
      game_over <= game_over_d;
      running   <= running_d;
      restart   <= restart_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ovl   <= '0;
      div   <= '0;
      frz   <= '0;
      score <= '0;
    end else begin
      ovl <= ((state_q == RUN) && !fe) ? ovl_next : '0;
      case (state_q)
        IDLE, OVER: begin
          if (start_req) begin
            score <= '0;
            div   <= '0;
          end
        end
        RUN: begin
          // A hit on the wrapping frame wins: no score step that frame.
          if (fe && hit_now) begin
            frz <= '0;
          end else if (fe) begin
            if (div == DIV_LAST) begin
              div <= '0;
              if (score != SC_MAX) score <= score + SCORE_W'(1);
            end else begin
              div <= div + DIV_W'(1);
            end
          end
        end
        HIT: begin
          if (fe) frz <= frz + FRZ_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule
